// File: rtl/exception_seq.sv
// Multicycle exception sequencer: writes EPC, fetches the handler vector byte
// from address 253/254/255 and loads it into PC, stalling main control meanwhile.
module exception_seq #(
  parameter int          MEM_LAT    = 1,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [2:0]  ctl_sel,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  srcaddr_sel,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic        pc_wr,
  output logic [31:0] pc_data,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_addr = 3'd1,
    st_wait = 3'd2,
    st_load = 3'd3,
    st_done = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [7:0]      vec_r, vec_s;
  logic [1:0]      cause_r, cause_s;
  logic            mem_unused_s;

  // Opcode beats overflow beats divide-by-zero; the cause code doubles as the
  // low bits of the vector mux select.
  function automatic logic [1:0] prio_cause(input logic op, input logic ov, input logic dz);
    logic [1:0] c;
    if (op) begin
      c = 2'b01;
    end else if (ov) begin
      c = 2'b10;
    end else if (dz) begin
      c = 2'b11;
    end else begin
      c = 2'b00;
    end
    return c;
  endfunction

  assign mem_unused_s = ^mem_rdata[31:8];

  // Next-state, counter, vector/cause capture and output decode.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    vec_s       = vec_r;
    cause_s     = cause_r;
    srcaddr_sel = ctl_sel;
    epc_wr      = 1'b0;
    pc_wr       = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (state_r)
      st_idle: begin
        busy = 1'b0;
        if (exc_opcode || exc_ovf || exc_div0) begin
          cause_s = prio_cause(exc_opcode, exc_ovf, exc_div0);
          state_s = st_addr;
        end else begin
          state_s = st_idle;
        end
      end
      st_addr: begin
        srcaddr_sel = {1'b0, cause_r};
        epc_wr      = 1'b1;
        cnt_s       = CW'(MEM_LAT - 1);
        state_s     = st_wait;
      end
      st_wait: begin
        srcaddr_sel = {1'b0, cause_r};
        if (cnt_r == '0) begin
          vec_s   = mem_rdata[7:0];
          state_s = st_load;
        end else begin
          cnt_s   = cnt_r - CW'(1);
          state_s = st_wait;
        end
      end
      st_load: begin
        srcaddr_sel = {1'b0, cause_r};
        pc_wr       = 1'b1;
        state_s     = st_done;
      end
      st_done: begin
        srcaddr_sel = 3'b000;
        done        = 1'b1;
        state_s     = st_idle;
      end
      default: begin
        srcaddr_sel = 3'b000;
        state_s     = st_idle;
      end
    endcase
  end

  assign epc_data = pc_in - EPC_OFFSET;
  assign pc_data  = {24'd0, vec_r};
  assign cause    = cause_r;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= st_idle;
      cnt_r   <= '0;
      vec_r   <= 8'd0;
      cause_r <= 2'b00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      vec_r   <= vec_s;
      cause_r <= cause_s;
    end
  end

endmodule

// File: tb/tb_exception_seq.sv
// Bench for exception_seq: two instances (MEM_LAT 1 and 3) share stimulus; a
// per-instance reference model queues expected pulses, a monitor pops and compares.
module tb_exception_seq;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_opcode = 1'b0, exc_ovf = 1'b0, exc_div0 = 1'b0;
  logic [2:0]  ctl_sel = 3'b000;
  logic [31:0] pc_in = 32'd0;
  logic [31:0] mem [256];
  logic [1:0]  busy_w;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          ending = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d got %h expected %h", name, g, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] addr_of(input logic [2:0] s);
    case (s)
      3'b001:  return 8'd253;
      3'b010:  return 8'd254;
      3'b011:  return 8'd255;
      3'b000:  return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [2:0]  srcaddr_sel;
    logic        epc_wr, pc_wr, done;
    logic [31:0] epc_data, pc_data, mem_rdata;
    logic [1:0]  cause;
    logic [31:0] pipe [L];
    ev_t         epc_q[$], pc_q[$], done_q[$];
    int          free_at = 0, st = -100, e, c;
    bit          ok = 1'b0, act = 1'b0, inseq, fin = 1'b0;
    logic [1:0]  cz = 2'b00;
    logic [7:0]  byt = 8'd0, lastv = 8'd0;
    logic [31:0] w;
    logic [2:0]  sel_exp;
    ev_t         ev;

    exception_seq #(.MEM_LAT(L), .EPC_OFFSET(32'd4)) dut (
      .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
      .exc_div0(exc_div0), .ctl_sel(ctl_sel), .pc_in(pc_in), .mem_rdata(mem_rdata),
      .srcaddr_sel(srcaddr_sel), .epc_wr(epc_wr), .epc_data(epc_data), .pc_wr(pc_wr),
      .pc_data(pc_data), .cause(cause), .busy(busy_w[g]), .done(done)
    );

    // Memory returning data L cycles after the address is presented.
    always @(posedge clk) begin
      pipe[0] <= mem[addr_of(srcaddr_sel)];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[L-1];

    // Reference model: decides acceptance at each edge and queues the expected pulses.
    initial forever begin
      @(posedge clk);
      e = cyc + 1;
      if (reset) begin
        ok = 1'b1; act = 1'b0; cz = 2'b00; lastv = 8'd0; free_at = e + 1;
        while (epc_q.size() != 0 && epc_q[$].cyc >= e) void'(epc_q.pop_back());
        while (pc_q.size() != 0 && pc_q[$].cyc >= e) void'(pc_q.pop_back());
        while (done_q.size() != 0 && done_q[$].cyc >= e) void'(done_q.pop_back());
      end else if (ok && e >= free_at && (exc_opcode || exc_ovf || exc_div0)) begin
        if (act) lastv = byt;
        cz = exc_opcode ? 2'd1 : (exc_ovf ? 2'd2 : 2'd3);
        w = mem[8'd252 + {6'd0, cz}];
        byt = w[7:0];
        st = e; act = 1'b1; free_at = e + L + 4;
        ev.cyc = e;         ev.data = pc_in - 32'd4;   epc_q.push_back(ev);
        ev.cyc = e + L + 1; ev.data = {24'd0, byt};    pc_q.push_back(ev);
        ev.cyc = e + L + 2; ev.data = 32'd0;           done_q.push_back(ev);
      end
    end

    // Monitor: per-cycle status checks plus scoreboard pops on pulses.
    initial forever begin
      @(negedge clk);
      if (ok) begin
        c = cyc;
        inseq = act && c >= st && c <= st + L + 2;
        sel_exp = !inseq ? ctl_sel : ((c == st + L + 2) ? 3'b000 : {1'b0, cz});
        chk("busy", g, 32'(busy_w[g]), 32'(inseq));
        chk("srcaddr_sel", g, 32'(srcaddr_sel), 32'(sel_exp));
        chk("cause", g, 32'(cause), 32'(cz));
        chk("pc_data", g, pc_data, (act && c >= st + L + 1) ? {24'd0, byt} : {24'd0, lastv});
        if (epc_q.size() != 0 && epc_q[0].cyc == c) begin
          ev = epc_q.pop_front();
          chk("epc_wr", g, 32'(epc_wr), 32'd1);
          chk("epc_data", g, epc_data, ev.data);
        end else chk("epc_wr", g, 32'(epc_wr), 32'd0);
        if (pc_q.size() != 0 && pc_q[0].cyc == c) begin
          ev = pc_q.pop_front();
          chk("pc_wr", g, 32'(pc_wr), 32'd1);
          chk("pc_wr_data", g, pc_data, ev.data);
        end else chk("pc_wr", g, 32'(pc_wr), 32'd0);
        if (done_q.size() != 0 && done_q[0].cyc == c) begin
          ev = done_q.pop_front();
          chk("done", g, 32'(done), 32'd1);
        end else chk("done", g, 32'(done), 32'd0);
      end
      if (ending && !fin) begin
        fin = 1'b1;
        chk("pending", g, 32'(epc_q.size() + pc_q.size() + done_q.size()), 32'd0);
      end
    end
  end

  task automatic step(input logic r, input logic op, input logic ov, input logic dz,
                      input logic [2:0] s, input logic [31:0] p);
    @(negedge clk);
    #1;
    reset = r; exc_opcode = op; exc_ovf = ov; exc_div0 = dz; ctl_sel = s; pc_in = p;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom), $urandom);
    while (busy_w != 2'b00 && n < 40) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom), $urandom);
      n++;
    end
    chk("idle_bound", -1, 32'(busy_w), 32'd0);
  endtask

  initial begin
    logic r, op, ov, dz;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0);
    wait_idle();

    // Overflow at pc 0x40, vector byte 0x8C.
    mem[254] = 32'h5A5A_A58C;
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 32'h40);
    wait_idle();

    // All three requests together: only the opcode sequence runs.
    mem[253] = 32'h1234_5611;
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'b111, 32'h1000);
    wait_idle();

    // Divide-by-zero held through the whole sequence and beyond.
    mem[255] = 32'hFFFF_FF7B;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h2000);
    wait_idle();

    // Reset held three cycles while both instances sit in WAIT.
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 32'h300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 32'h300);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 32'h300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 32'h300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 32'h300);
    wait_idle();

    // Div0 with upper read bits set, then opcode at pc 2 wrapping EPC.
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 32'h44);
    wait_idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h2);
    wait_idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'h8);

    // Random requests, select and PC, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      op = ($urandom_range(0, 9) == 0);
      ov = ($urandom_range(0, 7) == 0);
      dz = ($urandom_range(0, 6) == 0);
      step(r, op, ov, dz, 3'($urandom), $urandom);
    end
    wait_idle();

    ending = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
